cla_nibble_sequencer: RTL and testbench

CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_4bit.sv | 32 +++
 rtl/cla_nibble_sequencer.sv | 132 +++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA adder/subtractor.
// Holds the sequencer state encoding and the slice width.
package cla_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead slice with group propagate/generate.
// Zero latency; no flow control.
module cla_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out,
   output logic       pg,
   output logic       gg
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c[0] = c_in;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum   = p ^ c[3:0];
      c_out = c[4];
      pg    = &p;
      gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   end

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial add/subtract: one 4-bit CLA slice reused LSB nibble first.
// Result valid WIDTH/4+1 cycles after the handshake cycle; holds in DONE until out_ready.
module cla_nibble_sequencer
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             cout,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
      $error("cla_nibble_sequencer: WIDTH must be a positive multiple of 4");
   end

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;
   logic                last_nib;

   assign slice_a  = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign slice_b  = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

   cla_4bit u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .c_in  (carry_q),
      .sum   (slice_sum),
      .c_out (slice_cout),
      .pg    (),
      .gg    ()
   );

   // in_ready is masked by rst so the reset cycle never advertises acceptance.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE) && !rst;
   assign dout      = dout_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      dout_d  = dout_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = din1;
               b_d     = sub ? ~din2 : din2;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            dout_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_sum;
            carry_d = slice_cout;
            if (last_nib) begin
               // Overflow: operand signs agree but the result sign differs.
               cout_d  = slice_cout;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (slice_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Scoreboard bench for a 32-bit and a 4-bit sequencer instance.
// Stimulus pushes expected results; monitors pop and compare on out_valid & out_ready.
module tb_cla_nibble_sequencer;

   typedef struct {
      logic [31:0] dout;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0, in_ready, sub = 1'b0, cin = 1'b0;
   logic        out_valid, out_ready = 1'b1, cout, ovf;
   logic [31:0] din1 = '0, din2 = '0, dout;

   logic        in_valid4 = 1'b0, in_ready4, sub4 = 1'b0, cin4 = 1'b0;
   logic        out_valid4, out_ready4 = 1'b1, cout4, ovf4;
   logic [3:0]  din1_4 = '0, din2_4 = '0, dout4;

   exp_t exp32[$];
   exp_t exp4[$];
   int   cap32[$];
   int   cap4[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic ov32_prev = 1'b0;
   logic ov4_prev  = 1'b0;

   cla_nibble_sequencer #(.WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din1(din1), .din2(din2), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .cout(cout), .ovf(ovf)
   );

   cla_nibble_sequencer #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .din1(din1_4), .din2(din2_4), .cin(cin4), .sub(sub4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .dout(dout4), .cout(cout4), .ovf(ovf4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // 32-bit monitor: latency from handshake cycle, then result compare on acceptance.
   always @(negedge clk) begin
      if (rst) begin
         cap32.delete();
         ov32_prev = 1'b0;
      end else begin
         if (in_valid && in_ready) cap32.push_back(cyc);
         if (out_valid && !ov32_prev) begin
            if (cap32.size() == 0) flag("lat32 result without capture");
            else chk("lat32", cyc - cap32.pop_front(), 9);
         end
         ov32_prev = out_valid;
         if (out_valid && out_ready) begin
            if (exp32.size() == 0) flag("dout32 unexpected result");
            else begin
               exp_t e;
               e = exp32.pop_front();
               chk("dout32", dout, e.dout);
               chk("cout32", {31'd0, cout}, {31'd0, e.cout});
               chk("ovf32", {31'd0, ovf}, {31'd0, e.ovf});
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         cap4.delete();
         ov4_prev = 1'b0;
      end else begin
         if (in_valid4 && in_ready4) cap4.push_back(cyc);
         if (out_valid4 && !ov4_prev) begin
            if (cap4.size() == 0) flag("lat4 result without capture");
            else chk("lat4", cyc - cap4.pop_front(), 2);
         end
         ov4_prev = out_valid4;
         if (out_valid4 && out_ready4) begin
            if (exp4.size() == 0) flag("dout4 unexpected result");
            else begin
               exp_t e;
               e = exp4.pop_front();
               chk("dout4", {28'd0, dout4}, e.dout);
               chk("cout4", {31'd0, cout4}, {31'd0, e.cout});
               chk("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
            end
         end
      end
   end

   task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic sb, input logic track,
                          input logic [31:0] ed, input logic ec, input logic eo);
      exp_t e;
      e.dout = ed; e.cout = ec; e.ovf = eo;
      if (track) exp32.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b1; din1 = a; din2 = b; cin = ci; sub = sb;
   endtask

   task automatic finish32();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) flag("cap32 timeout waiting for in_ready");
      @(posedge clk); #1;
      in_valid = 1'b0; din1 = $urandom; din2 = $urandom;
      cin = 1'($urandom); sub = 1'($urandom);
   endtask

   task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic sb, input logic track,
                          input logic [31:0] ed, input logic ec, input logic eo);
      start32(a, b, ci, sb, track, ed, ec, eo);
      finish32();
   endtask

   task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic sb, input logic [3:0] ed, input logic ec, input logic eo);
      exp_t e;
      int n = 0;
      e.dout = {28'd0, ed}; e.cout = ec; e.ovf = eo;
      exp4.push_back(e);
      @(posedge clk); #1;
      in_valid4 = 1'b1; din1_4 = a; din2_4 = b; cin4 = ci; sub4 = sb;
      @(negedge clk);
      while (!in_ready4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready4) flag("cap4 timeout waiting for in_ready");
      @(posedge clk); #1;
      in_valid4 = 1'b0; din1_4 = 4'($urandom); din2_4 = 4'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp32.size() != 0 || exp4.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp32.size() != 0 || exp4.size() != 0) flag("drain timeout: results still pending");
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      issue32(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      issue32(32'd7, 32'd5, 1'b1, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
      issue32(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
      issue32(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      issue32(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, 1'b1, 32'h1010_1011, 1'b0, 1'b0);
      drain();

      // Backpressure: result held while a second request waits
      @(posedge clk); #1 out_ready = 1'b0;
      issue32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0);
      begin
         int n = 0;
         while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!out_valid) flag("bp timeout waiting for out_valid");
      end
      start32(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_dout", dout, 32'h2345_6789);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      finish32();
      drain();

      // Reset in the middle of RUN, at nibble index 3
      issue32(32'hAAAA_AAAA, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_dout", dout, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_post_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (12) @(negedge clk);
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
      issue32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0);
      drain();

      // Single-nibble instance
      issue4(4'h9, 4'h8, 1'b1, 1'b0, 4'h2, 1'b1, 1'b1);
      issue4(4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0);
      drain();

      chk("exp32_empty", exp32.size(), 32'd0);
      chk("exp4_empty", exp4.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
